// File: rtl/correction_pipe_u.sv
// Montgomery final-correction pipeline: folds a lazily-reduced product in [0,2q) or [0,4q)
// back into [0,q) with one or two conditional subtractions, under valid/ready flow control.
module correction_pipe_u #(
  parameter int              LOGQ   = 64,
  parameter int              LOGQH  = 17,
  parameter int              ID_W   = 4,
  parameter logic [LOGQH-1:0] QH_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [LOGQH-1:0]  cfg_qH,
  output logic              cfg_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LOGQ+1:0]   in_C,
  input  logic              in_mode,
  input  logic [ID_W-1:0]   in_id,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOGQ-1:0]   out_T,
  output logic              out_err,
  output logic [ID_W-1:0]   out_id
);

  localparam int R = LOGQ - LOGQH;
  localparam int W = LOGQ + 2;

  // Subtract b when it does not borrow; the borrow is the MSB of the W-bit difference.
  function automatic logic [W-1:0] cond_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a - b;
    return d[W-1] ? a : d;
  endfunction

  logic [LOGQH-1:0] qh_reg;
  logic [W-1:0]     q, q2;
  logic             vld_p0, vld_p1, vld_p2;
  logic [W-1:0]     c_p0, c_p1;
  logic             mode_p0;
  logic [ID_W-1:0]  id_p0, id_p1;
  logic             stall, cfg_load, accept;

  always_comb begin
    q = W'(qh_reg) << R;
    if (R != 0) q[0] = 1'b1;
    q2 = q << 1;
  end

  assign stall     = vld_p2 && !out_ready;
  assign cfg_ready = !(vld_p0 || vld_p1 || vld_p2);
  assign cfg_load  = cfg_we && cfg_ready;
  assign in_ready  = !stall && !cfg_load;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_p2;

  // Control state, qH and output register (cleared by reset)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qh_reg  <= QH_RST;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      out_T   <= '0;
      out_err <= 1'b0;
      out_id  <= '0;
    end else begin
      if (cfg_load) qh_reg <= cfg_qH;
      if (!stall) begin
        vld_p0  <= accept;
        vld_p1  <= vld_p0;
        vld_p2  <= vld_p1;
        // Stage 2: q subtraction, range check against 2q
        out_T   <= LOGQ'(cond_sub(c_p1, q));
        out_err <= (c_p1 >= q2);
        out_id  <= id_p1;
      end
    end
  end

  // Stage 0 capture and stage 1 (2q subtraction) datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      c_p0    <= in_C;
      mode_p0 <= in_mode;
      id_p0   <= in_id;
    end
    if (!stall) begin
      c_p1  <= mode_p0 ? cond_sub(c_p0, q2) : c_p0;
      id_p1 <= id_p0;
    end
  end

endmodule

// File: tb/tb_correction_pipe_u.sv
// Scoreboard bench for correction_pipe_u: main instance (LOGQ=16, LOGQH=8) plus R=0 and R=1 builds.
module tb_correction_pipe_u;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cfg_we, cfg_ready;
  logic [7:0]  cfg_qH;
  logic        in_valid, in_ready, in_mode;
  logic [17:0] in_C;
  logic [3:0]  in_id, out_id;
  logic        out_valid, out_ready, out_err;
  logic [15:0] out_T;

  logic        r0_cfg_we, r0_cfg_ready, r0_in_valid, r0_in_ready, r0_in_mode;
  logic [7:0]  r0_cfg_qH, r0_out_T;
  logic [9:0]  r0_in_C;
  logic [3:0]  r0_in_id, r0_out_id;
  logic        r0_out_valid, r0_out_err;

  logic        r1_cfg_we, r1_cfg_ready, r1_in_valid, r1_in_ready, r1_in_mode;
  logic [7:0]  r1_cfg_qH;
  logic [10:0] r1_in_C;
  logic [8:0]  r1_out_T;
  logic [3:0]  r1_in_id, r1_out_id;
  logic        r1_out_valid, r1_out_err;

  correction_pipe_u #(.LOGQ(16), .LOGQH(8), .ID_W(4), .QH_RST(8'h00)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_qH(cfg_qH), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_C(in_C), .in_mode(in_mode), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_T(out_T), .out_err(out_err), .out_id(out_id));

  correction_pipe_u #(.LOGQ(8), .LOGQH(8), .ID_W(4), .QH_RST(8'h00)) u_r0 (
    .clk(clk), .rst(rst), .cfg_we(r0_cfg_we), .cfg_qH(r0_cfg_qH), .cfg_ready(r0_cfg_ready),
    .in_valid(r0_in_valid), .in_ready(r0_in_ready), .in_C(r0_in_C), .in_mode(r0_in_mode),
    .in_id(r0_in_id), .out_valid(r0_out_valid), .out_ready(1'b1), .out_T(r0_out_T),
    .out_err(r0_out_err), .out_id(r0_out_id));

  correction_pipe_u #(.LOGQ(9), .LOGQH(8), .ID_W(4), .QH_RST(8'h00)) u_r1 (
    .clk(clk), .rst(rst), .cfg_we(r1_cfg_we), .cfg_qH(r1_cfg_qH), .cfg_ready(r1_cfg_ready),
    .in_valid(r1_in_valid), .in_ready(r1_in_ready), .in_C(r1_in_C), .in_mode(r1_in_mode),
    .in_id(r1_in_id), .out_valid(r1_out_valid), .out_ready(1'b1), .out_T(r1_out_T),
    .out_err(r1_out_err), .out_id(r1_out_id));

  typedef struct packed {
    logic [15:0] t;
    logic        e;
    logic [3:0]  id;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_x;
  int          n_chk, n_pass, n_out;
  logic [17:0] q_cur;
  logic [15:0] held_T;
  logic [3:0]  held_id;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference reduction: optional 2q step for mode 1, err if still >= 2q, then a q step.
  function automatic logic [16:0] model(input logic [17:0] c, input logic m, input logic [17:0] q);
    logic [19:0] v, qq;
    logic        e;
    v  = {2'b00, c};
    qq = {2'b00, q};
    if (m && v >= 2 * qq) v = v - 2 * qq;
    e = (v >= 2 * qq);
    if (v >= qq) v = v - qq;
    return {e, v[15:0]};
  endfunction

  // Called at posedge+1; leaves at posedge+1 after the accepting edge.
  task automatic send(input logic [17:0] c, input logic m, input logic [3:0] eid,
                      input logic [15:0] et, input logic ee);
    int n;
    n = 0;
    in_C = c; in_mode = m; in_id = eid; in_valid = 1'b1;
    #2;
    while (!in_ready && n < 100) begin
      @(posedge clk); #3;
      n++;
    end
    if (n >= 100) check_eq("in_ready_timeout", 64'd0, 64'd1);
    else sb.push_back('{t: et, e: ee, id: eid});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic sendm(input logic [17:0] c, input logic m, input logic [3:0] eid);
    logic [16:0] r;
    r = model(c, m, q_cur);
    send(c, m, eid, r[15:0], r[16]);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("drain_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) check_eq("unexpected_out", 64'd1, 64'd0);
      else begin
        mon_x = sb.pop_front();
        check_eq("out_T", 64'(out_T), 64'(mon_x.t));
        check_eq("out_err", 64'(out_err), 64'(mon_x.e));
        check_eq("out_id", 64'(out_id), 64'(mon_x.id));
      end
      n_out++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, out_base;
    n_chk = 0; n_pass = 0; n_out = 0;
    rst = 1'b0;
    cfg_we = 0; cfg_qH = '0; in_valid = 0; in_C = '0; in_mode = 0; in_id = '0; out_ready = 1;
    r0_cfg_we = 0; r0_cfg_qH = '0; r0_in_valid = 0; r0_in_C = '0; r0_in_mode = 0; r0_in_id = '0;
    r1_cfg_we = 0; r1_cfg_qH = '0; r1_in_valid = 0; r1_in_C = '0; r1_in_mode = 0; r1_in_id = '0;
    q_cur = 18'd1;
    #12;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_T", 64'(out_T), 64'd0);
    check_eq("rst_out_err", 64'(out_err), 64'd0);
    check_eq("rst_out_id", 64'(out_id), 64'd0);
    check_eq("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    cfg_we = 1; cfg_qH = 8'hC0;
    #2 check_eq("cfg_prio_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    cfg_we = 0;
    q_cur = 18'h0C001;

    send(18'd49152, 1'b0, 4'd1, 16'hC000, 1'b0);
    check_eq("lat_e0", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("lat_e1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("lat_e2", 64'(out_valid), 64'd1);
    send(18'd49153,  1'b0, 4'd2, 16'h0000, 1'b0);
    send(18'd98305,  1'b0, 4'd3, 16'hC000, 1'b0);
    send(18'd196611, 1'b1, 4'd4, 16'd49152, 1'b0);
    send(18'd150000, 1'b1, 4'd5, 16'd2541, 1'b0);
    send(18'd98306,  1'b1, 4'd6, 16'd0, 1'b0);
    send(18'd98306,  1'b0, 4'd7, 16'hC001, 1'b1);
    send(18'd196612, 1'b1, 4'd8, 16'hC001, 1'b1);
    wait_drain();

    out_base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          sendm(18'((i * 23456 + 777) % ((i % 2) != 0 ? 196612 : 98306)), 1'((i % 2)), 4'(i));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_stall_vld", 64'(out_valid), 64'd1);
        check_eq("pre_stall_in_ready", 64'(in_ready), 64'd1);
        out_ready = 0;
        held_T = out_T;
        held_id = out_id;
        repeat (4) begin
          @(negedge clk);
          check_eq("stall_in_ready", 64'(in_ready), 64'd0);
          check_eq("stall_vld", 64'(out_valid), 64'd1);
          check_eq("stall_hold_T", 64'(out_T), 64'(held_T));
          check_eq("stall_hold_id", 64'(out_id), 64'(held_id));
        end
        @(posedge clk); #1;
        out_ready = 1;
        #1 check_eq("post_stall_in_ready", 64'(in_ready), 64'd1);
      end
    join
    wait_drain();
    check_eq("stream_count", 64'(n_out - out_base), 64'd8);

    sendm(18'd30000, 1'b0, 4'd9);
    sendm(18'd60000, 1'b0, 4'd10);
    cfg_we = 1; cfg_qH = 8'h80;
    #2;
    check_eq("busy_cfg_ready", 64'(cfg_ready), 64'd0);
    check_eq("busy_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    cfg_we = 0;
    sendm(18'd70000, 1'b0, 4'd11);
    wait_drain();

    check_eq("idle_cfg_ready", 64'(cfg_ready), 64'd1);
    cfg_we = 1; cfg_qH = 8'h80;
    #2 check_eq("load_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    cfg_we = 0;
    q_cur = 18'h08001;
    send(18'h08001, 1'b0, 4'd12, 16'h0000, 1'b0);
    sendm(18'h08000, 1'b0, 4'd13);
    wait_drain();

    out_ready = 0;
    sendm(18'd100, 1'b0, 4'd1);
    sendm(18'd200, 1'b0, 4'd2);
    sendm(18'd300, 1'b0, 4'd3);
    check_eq("pre_rst_vld", 64'(out_valid), 64'd1);
    #1 rst = 1'b0;
    #1;
    check_eq("async_rst_vld", 64'(out_valid), 64'd0);
    check_eq("async_rst_T", 64'(out_T), 64'd0);
    check_eq("async_rst_cfg_ready", 64'(cfg_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1;
    @(posedge clk); #1;
    q_cur = 18'd1;
    send(18'd1, 1'b0, 4'd5, 16'd0, 1'b0);
    wait_drain();

    r0_cfg_we = 1; r0_cfg_qH = 8'hF1;
    r1_cfg_we = 1; r1_cfg_qH = 8'h80;
    @(posedge clk); #1;
    r0_cfg_we = 0; r1_cfg_we = 0;
    r0_in_valid = 1; r0_in_C = 10'h1E1; r0_in_mode = 0; r0_in_id = 4'd3;
    r1_in_valid = 1; r1_in_C = 11'h101; r1_in_mode = 0; r1_in_id = 4'd6;
    @(posedge clk); #1;
    r0_in_valid = 0; r1_in_valid = 0;
    n = 0;
    while (!r0_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("r0_out_valid", 64'(r0_out_valid), 64'd1);
    check_eq("r0_out_T", 64'(r0_out_T), 64'hF0);
    check_eq("r0_out_err", 64'(r0_out_err), 64'd0);
    check_eq("r0_out_id", 64'(r0_out_id), 64'd3);
    check_eq("r1_out_valid", 64'(r1_out_valid), 64'd1);
    check_eq("r1_out_T", 64'(r1_out_T), 64'd0);
    check_eq("r1_out_err", 64'(r1_out_err), 64'd0);
    check_eq("r1_out_id", 64'(r1_out_id), 64'd6);

    @(posedge clk); #1;
    r0_in_valid = 1; r0_in_C = 10'h0F1; r0_in_id = 4'd4;
    @(posedge clk); #1;
    r0_in_valid = 0;
    n = 0;
    while (!r0_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("r0_q_exact_T", 64'(r0_out_T), 64'd0);
    check_eq("r0_q_exact_id", 64'(r0_out_id), 64'd4);

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
